hidden_fwd_mac: RTL and testbench

//  Hidden-layer forward-pass engine, directly downstream of the architecture controller.

---
 rtl/hidden_fwd_mac.sv | 146 ++++++++++++++
 tb/tb_hidden_fwd_mac.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hidden_fwd_mac.sv
// Hidden-layer forward-pass engine.
// One pass per rising edge of fph: streams weight rows 0..N_IN-1 and the bias
// row N_IN from a 1-cycle-latency RAM, accumulates all N_HID neurons in
// parallel, then applies ReLU and saturation into h_out.
module hidden_fwd_mac #(
  parameter int N_IN  = 2,
  parameter int N_HID = 3,
  parameter int DW    = 8,
  parameter int FRAC  = 4,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fph,
  input  logic [N_IN*DW-1:0]    x_data,
  output logic [AW-1:0]         w_rd_addr,
  output logic                  w_rd_en,
  input  logic [N_HID*DW-1:0]   w_rd_data,
  output logic [N_HID*DW-1:0]   h_out,
  output logic                  h_valid,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PW    = 2 * DW;
  localparam int ACC_W = PW + $clog2(N_IN + 1);

  localparam logic signed [ACC_W-1:0] MAXV   = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic        [DW-1:0]    MAX_DW = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, READ, ACC, ACT} state_t;

  state_t                   state;
  logic                     fph_q;
  logic [N_IN*DW-1:0]       x_lat;
  logic [AW-1:0]            k;
  logic [N_HID*ACC_W-1:0]   acc;
  logic [N_HID*ACC_W-1:0]   acc_nxt;
  logic [N_HID*DW-1:0]      h_nxt;
  logic [N_HID-1:0]         clip;
  logic signed [DW-1:0]     xk;
  logic                     start;
  logic                     last;
  logic [AW:0]              nxt_addr;

  assign start    = fph & ~fph_q & (state == IDLE);
  assign last     = (k == AW'(N_IN));
  assign nxt_addr = {1'b0, k} + (AW+1)'(2);

  // Select the latched input that pairs with the weight row currently on w_rd_data
  always_comb begin
    xk = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (k == AW'(i)) xk = x_lat[i*DW +: DW];
    end
  end

  for (genvar j = 0; j < N_HID; j++) begin : g_neuron
    logic signed [DW-1:0]    wv;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_j;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sh;

    assign wv    = w_rd_data[j*DW +: DW];
    assign acc_j = acc[j*ACC_W +: ACC_W];
    assign prod  = xk * wv;
    assign sh    = acc_j >>> FRAC;

    // Accumulate a product for weight rows, or the Q-aligned bias on the final row
    always_comb begin
      if (last) term = {{(ACC_W-DW){wv[DW-1]}}, wv} << FRAC;
      else      term = {{(ACC_W-PW){prod[PW-1]}}, prod};
      acc_nxt[j*ACC_W +: ACC_W] = acc_j + term;
    end

    // ReLU then clip the rescaled sum to the largest positive data value
    always_comb begin
      clip[j] = 1'b0;
      if (sh[ACC_W-1]) begin
        h_nxt[j*DW +: DW] = '0;
      end else if (sh > MAXV) begin
        h_nxt[j*DW +: DW] = MAX_DW;
        clip[j]           = 1'b1;
      end else begin
        h_nxt[j*DW +: DW] = sh[DW-1:0];
      end
    end
  end

  // Pass sequencer with registered RAM controls and results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fph_q     <= 1'b0;
      x_lat     <= '0;
      k         <= '0;
      acc       <= '0;
      h_out     <= '0;
      h_valid   <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
    end else begin
      fph_q   <= fph;
      h_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_lat     <= x_data;
            acc       <= '0;
            ovf       <= 1'b0;
            k         <= '0;
            w_rd_en   <= 1'b1;
            w_rd_addr <= '0;
            busy      <= 1'b1;
            state     <= READ;
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          w_rd_addr <= AW'(1);
          state     <= ACC;
        end
        ACC: begin
          acc <= acc_nxt;
          // Reads run two rows ahead of the row being accumulated
          if (nxt_addr <= (AW+1)'(N_IN)) w_rd_addr <= nxt_addr[AW-1:0];
          else                           w_rd_en   <= 1'b0;
          if (last) state <= ACT;
          else      k     <= k + AW'(1);
        end
        ACT: begin
          h_out   <= h_nxt;
          h_valid <= 1'b1;
          ovf     <= |clip;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_fwd_mac.sv
// Self-checking bench for hidden_fwd_mac: RAM model, result scoreboard,
// per-cycle address/handshake checks and strobe-rule scenarios.
module tb_hidden_fwd_mac;

  localparam int N_IN  = 2;
  localparam int N_HID = 3;
  localparam int DW    = 8;
  localparam int AW    = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  fph = 1'b0;
  logic [N_IN*DW-1:0]    x_data = '0;
  logic [AW-1:0]         w_rd_addr;
  logic                  w_rd_en;
  logic [N_HID*DW-1:0]   w_rd_data = '0;
  logic [N_HID*DW-1:0]   h_out;
  logic                  h_valid;
  logic                  busy;
  logic                  ovf;

  logic [N_HID*DW-1:0]   ram [16];
  logic [N_HID*DW-1:0]   q_h [$];
  logic                  q_o [$];

  int n_tests  = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_pushed = 0;

  hidden_fwd_mac #(.N_IN(N_IN), .N_HID(N_HID), .DW(DW), .FRAC(4), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fph       (fph),
    .x_data    (x_data),
    .w_rd_addr (w_rd_addr),
    .w_rd_en   (w_rd_en),
    .w_rd_data (w_rd_data),
    .h_out     (h_out),
    .h_valid   (h_valid),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Weight RAM with one cycle of read latency
  always @(posedge clk) if (w_rd_en) w_rd_data <= ram[w_rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed Q4.4 dot product plus bias, floor shift, ReLU, clip
  function automatic void model(input logic [15:0] x, output logic [23:0] h, output logic o);
    logic signed [7:0] xv, wv, bv;
    int sum, s;
    h = '0;
    o = 1'b0;
    for (int j = 0; j < N_HID; j++) begin
      sum = 0;
      for (int i = 0; i < N_IN; i++) begin
        xv  = x[i*8 +: 8];
        wv  = ram[i][j*8 +: 8];
        sum = sum + int'(xv) * int'(wv);
      end
      bv  = ram[N_IN][j*8 +: 8];
      sum = sum + int'(bv) * 16;
      s   = sum >>> 4;
      if (s < 0) s = 0;
      if (s > 127) begin
        s = 127;
        o = 1'b1;
      end
      h[j*8 +: 8] = s[7:0];
    end
  endfunction

  // Scoreboard: every h_valid pulse consumes one expected result
  always @(negedge clk) begin
    if (!rst && h_valid) begin
      n_valid++;
      if (q_h.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("h_out", h_out, q_h.pop_front());
        check("ovf", ovf, q_o.pop_front());
      end
    end
  end

  task automatic set_rows(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] b);
    ram[0] = r0;
    ram[1] = r1;
    ram[2] = b;
  endtask

  // mode 0: single-cycle strobe; 1: fph held 10 cycles; 2: x change at T+1 and
  // re-rise at T+2; 3: re-rise sampled in the ACT cycle. Called just after a negedge.
  task automatic do_pass(input logic [15:0] x, input int mode, input logic fixed,
                         input logic [23:0] eh, input logic eo, input int tail);
    logic [23:0] mh;
    logic        mo;
    x_data = x;
    fph    = 1'b1;
    if (fixed) begin
      mh = eh;
      mo = eo;
    end else begin
      model(x, mh, mo);
    end
    q_h.push_back(mh);
    q_o.push_back(mo);
    n_pushed++;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check("w_rd_en", w_rd_en, (c <= N_IN) ? 32'd1 : 32'd0);
      check("w_rd_addr", w_rd_addr, (c <= N_IN) ? c : N_IN);
      check("busy", busy, (c <= 5) ? 32'd1 : 32'd0);
      check("h_valid", h_valid, (c == 5) ? 32'd1 : 32'd0);
      if (c == 0 && mode != 1) fph = 1'b0;
      if (mode == 2) begin
        if (c == 0) x_data = ~x;
        if (c == 1) fph = 1'b1;
        if (c == 2) fph = 1'b0;
      end
      if (mode == 3) begin
        if (c == 4) fph = 1'b1;
        if (c == 5) fph = 1'b0;
      end
    end
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      check("hold_no_restart", busy, 32'd0);
      fph = 1'b0;
    end
    repeat (tail) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_h_out", h_out, 32'd0);
    check("rst_h_valid", h_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ovf", ovf, 32'd0);
    check("rst_w_rd_en", w_rd_en, 32'd0);
    check("rst_w_rd_addr", w_rd_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: no bias, neuron 1 negative, neuron 2 clips
    set_rows(24'h70F010, 24'h700008, 24'h000000);
    do_pass(16'h2010, 0, 1'b1, 24'h7F0020, 1'b1, 2);

    // Bias row
    set_rows(24'h70F010, 24'h700008, 24'h003010);
    do_pass(16'h2010, 0, 1'b1, 24'h7F2030, 1'b1, 2);

    // Asynchronous reset in the middle of ACC aborts the pass
    x_data = 16'h2010;
    fph    = 1'b1;
    @(negedge clk);
    fph = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_h_out", h_out, 32'd0);
    check("abort_h_valid", h_valid, 32'd0);
    check("abort_busy", busy, 32'd0);
    check("abort_ovf", ovf, 32'd0);
    check("abort_w_rd_en", w_rd_en, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Strobe rules
    do_pass(16'h2010, 1, 1'b1, 24'h7F2030, 1'b1, 1);
    do_pass(16'h2010, 2, 1'b1, 24'h7F2030, 1'b1, 1);
    set_rows(24'h70F010, 24'h700008, 24'h000000);
    do_pass(16'h2010, 3, 1'b1, 24'h7F0020, 1'b1, 0);

    // Back-to-back: clipping pass followed directly by a clean pass
    do_pass(16'h2010, 0, 1'b1, 24'h7F0020, 1'b1, 0);
    set_rows(24'h081010, 24'h080808, 24'h000000);
    do_pass(16'h1010, 0, 1'b1, 24'h101818, 1'b0, 1);

    // Random data, including negative inputs and weights
    for (int t = 0; t < 8; t++) begin
      set_rows(24'($urandom), 24'($urandom), 24'($urandom));
      do_pass(16'($urandom), 0, 1'b0, 24'h0, 1'b0, int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", q_h.size(), 32'd0);
    check("valid_count", n_valid, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
